// File: rtl/i2c_slave_regs.sv
// I2C slave exposing an 8 x 8-bit register file with an auto-incrementing pointer.
// Latency: SCL/SDA changes are acted on about 7 clk cycles after the pin moves (sync + filter + edge).
// Backpressure: none; the block never stretches SCL and only pulls SDA low or releases it.
//
// Ports:
//   clk, rst           single clock, synchronous active-low reset
//   i2c_scl_i          SCL line level (input only, never driven)
//   i2c_sda_i          SDA line level
//   i2c_sda_o/_t       SDA drive value / tristate enable (1 = released)
//   regs_o             register image, reg[n] at bits 8n+7:8n
//   wr_stb_o/wr_idx_o  one-cycle pulse and index for each register written over I2C
//   busy_o             high while addressed (ADDR_ACK through RD_ACK)
module i2c_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         FILT_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_scl_i,
  input  logic        i2c_sda_i,
  output logic        i2c_sda_o,
  output logic        i2c_sda_t,
  output logic [63:0] regs_o,
  output logic        wr_stb_o,
  output logic [2:0]  wr_idx_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer, then a filter that only accepts a
  // new level once FILT_LEN consecutive synchronized samples agree.
  // ---------------------------------------------------------------------------
  logic                r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic [FILT_LEN-1:0] r_scl_hist, r_sda_hist;
  logic                r_scl_f, r_scl_fd, r_sda_f, r_sda_fd;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
      r_scl_fd   <= 1'b1;
      r_sda_fd   <= 1'b1;
    end else begin
      r_scl_s1   <= i2c_scl_i;
      r_scl_s2   <= r_scl_s1;
      r_sda_s1   <= i2c_sda_i;
      r_sda_s2   <= r_sda_s1;
      r_scl_hist <= {r_scl_hist[FILT_LEN-2:0], r_scl_s2};
      r_sda_hist <= {r_sda_hist[FILT_LEN-2:0], r_sda_s2};
      if (&r_scl_hist)       r_scl_f <= 1'b1;
      else if (~|r_scl_hist) r_scl_f <= 1'b0;
      if (&r_sda_hist)       r_sda_f <= 1'b1;
      else if (~|r_sda_hist) r_sda_f <= 1'b0;
      r_scl_fd   <= r_scl_f;
      r_sda_fd   <= r_sda_f;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_scl_f & ~r_scl_fd;
  assign w_scl_fall = ~r_scl_f & r_scl_fd;
  // Bus conditions require SCL to have been high on both sides of the SDA edge.
  assign w_start    = ~r_sda_f & r_sda_fd & r_scl_f & r_scl_fd;
  assign w_stop     = r_sda_f & ~r_sda_fd & r_scl_f & r_scl_fd;

  // ---------------------------------------------------------------------------
  // Protocol FSM and register file
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;     // receive shifter, or latched read byte while in RD_BYTE
  logic [2:0] r_ptr;
  logic       r_rw;
  logic       r_first;     // next received byte is the pointer byte
  logic       r_ack;
  logic       r_drive;     // 1 = pull SDA low
  logic       r_wr_stb;
  logic [2:0] r_wr_idx;
  logic [7:0] r_regs [0:7];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_ptr     <= 3'd0;
      r_rw      <= 1'b0;
      r_first   <= 1'b0;
      r_ack     <= 1'b1;
      r_drive   <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_idx  <= 3'd0;
      for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_stop) begin
        r_state <= IDLE;
        r_drive <= 1'b0;
      end else if (w_start) begin
        // Start or repeated start; ptr is deliberately kept.
        r_state   <= ADDR;
        r_bit_cnt <= 4'd0;
        r_drive   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: ;

          ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], r_sda_f};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_rw <= r_shift[0];
              if (r_shift[7:1] == DEV_ADDR) begin
                r_state <= ADDR_ACK;
                r_drive <= 1'b1;
              end else begin
                r_state <= WAIT_STOP;
                r_drive <= 1'b0;
              end
            end
          end

          ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (!r_rw) begin
                r_state <= WR_BYTE;
                r_drive <= 1'b0;
                r_first <= 1'b1;
              end else begin
                r_state <= RD_BYTE;
                r_shift <= r_regs[r_ptr];
                r_drive <= ~r_regs[r_ptr][7];
              end
            end
          end

          WR_BYTE: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], r_sda_f};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              if (r_first) begin
                r_ptr   <= r_shift[2:0];
                r_first <= 1'b0;
              end else begin
                r_regs[r_ptr] <= r_shift;
                r_wr_stb      <= 1'b1;
                r_wr_idx      <= r_ptr;
                r_ptr         <= r_ptr + 3'd1;
              end
              r_state <= WR_ACK;
              r_drive <= 1'b1;
            end
          end

          WR_ACK: begin
            if (w_scl_fall) begin
              r_state   <= WR_BYTE;
              r_drive   <= 1'b0;
              r_bit_cnt <= 4'd0;
            end
          end

          RD_BYTE: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_state <= RD_ACK;
                r_drive <= 1'b0;
                r_ptr   <= r_ptr + 3'd1;
              end else begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_drive <= ~r_shift[6];
              end
            end
          end

          RD_ACK: begin
            if (w_scl_rise) begin
              r_ack <= r_sda_f;
            end else if (w_scl_fall) begin
              if (!r_ack) begin
                r_state   <= RD_BYTE;
                r_shift   <= r_regs[r_ptr];
                r_drive   <= ~r_regs[r_ptr][7];
                r_bit_cnt <= 4'd0;
              end else begin
                r_state <= WAIT_STOP;
                r_drive <= 1'b0;
              end
            end
          end

          WAIT_STOP: r_drive <= 1'b0;

          default: begin
            r_state <= IDLE;
            r_drive <= 1'b0;
          end
        endcase
      end
    end
  end

  // SDA is open-drain: drive low or release, never drive high.
  assign i2c_sda_o = ~r_drive;
  assign i2c_sda_t = ~r_drive;
  assign wr_stb_o  = r_wr_stb;
  assign wr_idx_o  = r_wr_idx;
  assign busy_o    = (r_state == ADDR_ACK) || (r_state == WR_BYTE) || (r_state == WR_ACK) ||
                     (r_state == RD_BYTE)  || (r_state == RD_ACK);

  always_comb begin
    regs_o = 64'h0;
    for (int i = 0; i < 8; i++) regs_o[8*i +: 8] = r_regs[i];
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed testbench for i2c_slave_regs: bit-banged I2C master with open-drain SDA.
// Latency: master phases are Q clk cycles, well above the slave's input pipeline delay.
// Backpressure: not applicable; the slave never stretches SCL.
module tb_i2c_slave_regs;
  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        sda_m;
  logic        sda_line;
  logic        i2c_sda_o, i2c_sda_t;
  logic [63:0] regs_o;
  logic        wr_stb_o;
  logic [2:0]  wr_idx_o;
  logic        busy_o;

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull low.
  assign sda_line = sda_m & (i2c_sda_t | i2c_sda_o);

  i2c_slave_regs #(.DEV_ADDR(7'h50), .FILT_LEN(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl_i(scl),
    .i2c_sda_i(sda_line),
    .i2c_sda_o(i2c_sda_o),
    .i2c_sda_t(i2c_sda_t),
    .regs_o   (regs_o),
    .wr_stb_o (wr_stb_o),
    .wr_idx_o (wr_idx_o),
    .busy_o   (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitors
  int unsigned stb_q[$];
  int          illegal_cnt = 0;
  logic        busy_seen = 1'b0;

  always @(negedge clk) begin
    if (wr_stb_o === 1'b1) stb_q.push_back(32'(wr_idx_o));
    if (i2c_sda_o !== i2c_sda_t) illegal_cnt++;
    if (busy_o === 1'b1) busy_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer_bit(input logic b, input logic glitch, output logic r);
    sda_m = b;
    cyc(Q);
    scl = 1'b1;
    if (glitch) begin
      cyc(Q / 2);
      scl = 1'b0;
      cyc(1);
      scl = 1'b1;
      cyc(Q / 2 - 1);
    end else begin
      cyc(Q);
    end
    r = sda_line;
    cyc(Q);
    scl = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    cyc(Q);
    scl = 1'b1;
    cyc(Q);
    sda_m = 1'b0;
    cyc(Q);
    scl = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    cyc(Q);
    scl = 1'b1;
    cyc(Q);
    sda_m = 1'b1;
    cyc(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input int gbit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], (i == gbit), r);
    xfer_bit(1'b1, 1'b0, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    xfer_bit(nack, 1'b0, r);
  endtask

  function automatic logic [63:0] stb_at(input int k);
    if (k < stb_q.size()) return 64'(stb_q[k]);
    return 'x;
  endfunction

  logic       ack;
  logic [7:0] rd;

  initial begin
    rst   = 1'b0;
    scl   = 1'b1;
    sda_m = 1'b1;
    cyc(5);
    check("rst_regs", regs_o, 64'h0);
    check("rst_sda_o", i2c_sda_o, 1'b1);
    check("rst_sda_t", i2c_sda_t, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_stb", {wr_stb_o, wr_idx_o}, 4'h0);
    rst = 1'b1;
    cyc(10);

    // Write burst starting at reg2
    stb_q.delete();
    i2c_start();
    wr_byte(8'hA0, -1, ack); check("wr_addr_ack", ack, 1'b0);
    check("wr_busy", busy_o, 1'b1);
    wr_byte(8'h02, -1, ack); check("wr_ptr_ack", ack, 1'b0);
    wr_byte(8'h11, -1, ack); check("wr_d0_ack", ack, 1'b0);
    wr_byte(8'h22, -1, ack); check("wr_d1_ack", ack, 1'b0);
    i2c_stop();
    check("wr_regs", regs_o, 64'h00000000_22110000);
    check("wr_stb_cnt", stb_q.size(), 2);
    check("wr_stb_idx0", stb_at(0), 2);
    check("wr_stb_idx1", stb_at(1), 3);
    check("wr_busy_after_stop", busy_o, 1'b0);

    // Pointer wrap 7 -> 0
    stb_q.delete();
    i2c_start();
    wr_byte(8'hA0, -1, ack); check("wrap_addr_ack", ack, 1'b0);
    wr_byte(8'h07, -1, ack); check("wrap_ptr_ack", ack, 1'b0);
    wr_byte(8'hAA, -1, ack); check("wrap_d0_ack", ack, 1'b0);
    wr_byte(8'hBB, -1, ack); check("wrap_d1_ack", ack, 1'b0);
    i2c_stop();
    check("wrap_regs", regs_o, 64'hAA000000_221100BB);
    check("wrap_stb_idx0", stb_at(0), 7);
    check("wrap_stb_idx1", stb_at(1), 0);

    // Set pointer, repeated start, read two bytes
    stb_q.delete();
    i2c_start();
    wr_byte(8'hA0, -1, ack); check("rd_waddr_ack", ack, 1'b0);
    wr_byte(8'h02, -1, ack); check("rd_ptr_ack", ack, 1'b0);
    i2c_start();
    wr_byte(8'hA1, -1, ack); check("rd_raddr_ack", ack, 1'b0);
    rd_byte(1'b0, rd); check("rd_byte0", rd, 8'h11);
    check("rd_busy", busy_o, 1'b1);
    rd_byte(1'b1, rd); check("rd_byte1", rd, 8'h22);
    check("rd_released_after_nack", i2c_sda_t, 1'b1);
    check("rd_not_busy_after_nack", busy_o, 1'b0);
    i2c_stop();
    check("rd_regs_unchanged", regs_o, 64'hAA000000_221100BB);
    check("rd_no_stb", stb_q.size(), 0);

    // Address mismatch
    busy_seen = 1'b0;
    i2c_start();
    wr_byte(8'hA2, -1, ack); check("mis_nack", ack, 1'b1);
    i2c_stop();
    check("mis_busy", busy_seen, 1'b0);
    check("mis_regs", regs_o, 64'hAA000000_221100BB);

    // One-cycle SCL low glitch inside a data byte
    i2c_start();
    wr_byte(8'hA0, -1, ack); check("gl_addr_ack", ack, 1'b0);
    wr_byte(8'h04, -1, ack); check("gl_ptr_ack", ack, 1'b0);
    wr_byte(8'h5A, 3, ack);  check("gl_data_ack", ack, 1'b0);
    i2c_stop();
    check("gl_regs", regs_o, 64'hAA00005A_221100BB);

    // Reset while the slave is driving a 0 data bit
    i2c_start();
    wr_byte(8'hA0, -1, ack);
    wr_byte(8'h02, -1, ack);
    i2c_start();
    wr_byte(8'hA1, -1, ack); check("rr_raddr_ack", ack, 1'b0);
    check("rr_driving", i2c_sda_t, 1'b0);
    rst = 1'b0;
    cyc(1);
    check("rr_released", i2c_sda_t, 1'b1);
    check("rr_sda_o", i2c_sda_o, 1'b1);
    check("rr_regs", regs_o, 64'h0);
    check("rr_busy", busy_o, 1'b0);
    cyc(2);
    rst = 1'b1;
    cyc(2 * Q);
    stb_q.delete();
    i2c_start();
    wr_byte(8'hA0, -1, ack); check("rr2_addr_ack", ack, 1'b0);
    wr_byte(8'h01, -1, ack); check("rr2_ptr_ack", ack, 1'b0);
    wr_byte(8'h33, -1, ack); check("rr2_data_ack", ack, 1'b0);
    i2c_stop();
    check("rr2_regs", regs_o, 64'h00000000_00003300);
    check("rr2_stb_idx", stb_at(0), 1);

    check("sda_legal", illegal_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
